// File: rtl/VX_gpu_pkg.sv
// rtl/VX_gpu_pkg.sv - shared GPU types: CSR op encodings, CSR request struct, helpers
//
// Contents:
//   UUID_WIDTH, CSR_NUM_WARPS_DEF, CSR_XLEN_DEF, CSR_NW_WIDTH_DEF : core-wide widths
//   CSR_OP_RO/RW/RS/RC : 2-bit CSR operation encodings
//   csr_req_t          : latched CSR request (uuid, wid, addr, op, src, src_zero)
//   csr_is_read_only() : CSR address space read-only test
package VX_gpu_pkg;

    localparam int UUID_WIDTH        = 44;
    localparam int CSR_NUM_WARPS_DEF = 4;
    localparam int CSR_XLEN_DEF      = 32;
    localparam int CSR_NW_WIDTH_DEF  = (CSR_NUM_WARPS_DEF > 1) ? $clog2(CSR_NUM_WARPS_DEF) : 1;

    localparam logic [1:0] CSR_OP_RO = 2'b00;
    localparam logic [1:0] CSR_OP_RW = 2'b01;
    localparam logic [1:0] CSR_OP_RS = 2'b10;
    localparam logic [1:0] CSR_OP_RC = 2'b11;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]       uuid;
        logic [CSR_NW_WIDTH_DEF-1:0] wid;
        logic [11:0]                 addr;
        logic [1:0]                  op;
        logic [CSR_XLEN_DEF-1:0]     src;
        logic                        src_zero;
    } csr_req_t;

    // The top two address bits encode accessibility; 2'b11 is read-only space.
    function automatic logic csr_is_read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/vx_csr_access_unit.sv
// rtl/vx_csr_access_unit.sv - CSR read/modify/write sequencer between SFU dispatch and CSR data block
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   req_*                      : decoded CSR request from SFU (valid/ready)
//   rsp_*                      : old CSR value + illegal flag to writeback (valid/ready)
//   read_enable/uuid/wid/addr  : read strobe to CSR data block
//   read_data_ro/read_data_rw  : combinational read data returned by the CSR data block
//   write_enable/uuid/wid/addr/data : single-cycle write strobe to CSR data block
//   perf_accesses              : count of completed responses (wraps)
module vx_csr_access_unit
    import VX_gpu_pkg::*;
#(
    parameter int NUM_WARPS     = CSR_NUM_WARPS_DEF,
    parameter int XLEN          = CSR_XLEN_DEF,
    parameter int PERF_CTR_BITS = 44,
    localparam int NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [UUID_WIDTH-1:0]    req_uuid,
    input  logic [NW_WIDTH-1:0]      req_wid,
    input  logic [11:0]              req_addr,
    input  logic [1:0]               req_op,
    input  logic [XLEN-1:0]          req_src,
    input  logic                     req_src_zero,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [UUID_WIDTH-1:0]    rsp_uuid,
    output logic [NW_WIDTH-1:0]      rsp_wid,
    output logic [XLEN-1:0]          rsp_data,
    output logic                     rsp_illegal,

    output logic                     read_enable,
    output logic [UUID_WIDTH-1:0]    read_uuid,
    output logic [NW_WIDTH-1:0]      read_wid,
    output logic [11:0]              read_addr,
    input  logic [XLEN-1:0]          read_data_ro,
    input  logic [XLEN-1:0]          read_data_rw,

    output logic                     write_enable,
    output logic [UUID_WIDTH-1:0]    write_uuid,
    output logic [NW_WIDTH-1:0]      write_wid,
    output logic [11:0]              write_addr,
    output logic [XLEN-1:0]          write_data,

    output logic [PERF_CTR_BITS-1:0] perf_accesses
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t          state;
    csr_req_t        req_q;
    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] new_q;

    logic            req_fire;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic            write_intent;
    logic            read_only;
    logic            do_write;

    // A new request may be taken in the same cycle the previous response retires.
    assign req_ready = !reset && ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
    assign req_fire  = req_valid && req_ready;

    // The data block returns zero on the bank that does not own the address.
    assign old_val = read_data_ro | read_data_rw;

    always_comb begin
        new_val = old_val;
        case (req_q.op)
            CSR_OP_RW: new_val = req_q.src;
            CSR_OP_RS: new_val = old_val | req_q.src;
            CSR_OP_RC: new_val = old_val & ~req_q.src;
            default:   new_val = old_val;
        endcase
    end

    // Set/clear with a zero operand is architecturally a pure read.
    assign write_intent = (req_q.op == CSR_OP_RW)
                       || (((req_q.op == CSR_OP_RS) || (req_q.op == CSR_OP_RC)) && !req_q.src_zero);
    assign read_only    = csr_is_read_only(req_q.addr);
    assign do_write     = write_intent && !read_only;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            rsp_valid     <= 1'b0;
            rsp_illegal   <= 1'b0;
            read_enable   <= 1'b0;
            write_enable  <= 1'b0;
            perf_accesses <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        req_q       <= '{req_uuid, req_wid, req_addr, req_op, req_src, req_src_zero};
                        read_enable <= 1'b1;
                        state       <= ST_READ;
                    end
                end
                ST_READ: begin
                    read_enable <= 1'b0;
                    old_q       <= old_val;
                    new_q       <= new_val;
                    rsp_illegal <= write_intent && read_only;
                    if (do_write) begin
                        write_enable <= 1'b1;
                        state        <= ST_WRITE;
                    end else begin
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    write_enable <= 1'b0;
                    rsp_valid    <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid     <= 1'b0;
                        perf_accesses <= perf_accesses + {{(PERF_CTR_BITS-1){1'b0}}, 1'b1};
                        if (req_fire) begin
                            req_q       <= '{req_uuid, req_wid, req_addr, req_op, req_src, req_src_zero};
                            read_enable <= 1'b1;
                            state       <= ST_READ;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign read_uuid  = req_q.uuid;
    assign read_wid   = req_q.wid;
    assign read_addr  = req_q.addr;
    assign write_uuid = req_q.uuid;
    assign write_wid  = req_q.wid;
    assign write_addr = req_q.addr;
    assign write_data = new_q;
    assign rsp_uuid   = req_q.uuid;
    assign rsp_wid    = req_q.wid;
    assign rsp_data   = old_q;

endmodule

// File: tb/tb_vx_csr_access_unit.sv
// tb/tb_vx_csr_access_unit.sv - self-checking bench for vx_csr_access_unit
module tb_vx_csr_access_unit;
    import VX_gpu_pkg::*;

    localparam int XLEN = CSR_XLEN_DEF;
    localparam int NWW  = CSR_NW_WIDTH_DEF;
    localparam int PCB  = 44;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic [UUID_WIDTH-1:0] req_uuid = '0;
    logic [NWW-1:0]        req_wid = '0;
    logic [11:0]           req_addr = '0;
    logic [1:0]            req_op = '0;
    logic [XLEN-1:0]       req_src = '0;
    logic                  req_src_zero = 1'b0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [UUID_WIDTH-1:0] rsp_uuid;
    logic [NWW-1:0]        rsp_wid;
    logic [XLEN-1:0]       rsp_data;
    logic                  rsp_illegal;
    logic                  read_enable;
    logic [UUID_WIDTH-1:0] read_uuid;
    logic [NWW-1:0]        read_wid;
    logic [11:0]           read_addr;
    logic [XLEN-1:0]       read_data_ro;
    logic [XLEN-1:0]       read_data_rw;
    logic                  write_enable;
    logic [UUID_WIDTH-1:0] write_uuid;
    logic [NWW-1:0]        write_wid;
    logic [11:0]           write_addr;
    logic [XLEN-1:0]       write_data;
    logic [PCB-1:0]        perf_accesses;

    vx_csr_access_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid), .req_wid(req_wid),
        .req_addr(req_addr), .req_op(req_op), .req_src(req_src), .req_src_zero(req_src_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid), .rsp_wid(rsp_wid),
        .rsp_data(rsp_data), .rsp_illegal(rsp_illegal),
        .read_enable(read_enable), .read_uuid(read_uuid), .read_wid(read_wid), .read_addr(read_addr),
        .read_data_ro(read_data_ro), .read_data_rw(read_data_rw),
        .write_enable(write_enable), .write_uuid(write_uuid), .write_wid(write_wid),
        .write_addr(write_addr), .write_data(write_data),
        .perf_accesses(perf_accesses)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // CSR data block model (environment) and the reference view of CSR contents.
    logic [XLEN-1:0] blk_mem [4096];
    logic [XLEN-1:0] ref_mem [4096];

    assign read_data_rw = (read_addr[11:10] != 2'b11) ? blk_mem[read_addr] : '0;
    assign read_data_ro = (read_addr[11:10] == 2'b11) ? blk_mem[read_addr] : '0;

    always @(posedge clk) if (write_enable === 1'b1) blk_mem[write_addr] <= write_data;

    // Reference model: per-transaction expectations derived from the CSR rules.
    logic                  mon_on = 1'b0;
    logic                  busy = 1'b0;
    int                    age = 0;
    logic [UUID_WIDTH-1:0] cur_uuid;
    logic [NWW-1:0]        cur_wid;
    logic [11:0]           cur_addr;
    logic [XLEN-1:0]       cur_old, cur_new;
    logic                  cur_wr, cur_ill;
    logic [PCB-1:0]        perf_m = '0;

    always @(negedge clk) begin
        logic exp_rv, exp_ready, intent, ro;
        int   rstart;
        if (mon_on) begin
            if (busy) age++;
            rstart    = cur_wr ? 3 : 2;
            exp_rv    = busy && (age >= rstart);
            exp_ready = !reset && (!busy || (exp_rv && rsp_ready));
            check_eq("rsp_valid", rsp_valid, exp_rv);
            check_eq("read_enable", read_enable, busy && age == 1);
            check_eq("write_enable", write_enable, busy && cur_wr && age == 2);
            check_eq("req_ready", req_ready, exp_ready);
            check_eq("perf_accesses", perf_accesses, perf_m);
            if (busy && age == 1) begin
                check_eq("read_addr", read_addr, cur_addr);
                check_eq("read_uuid", read_uuid, cur_uuid);
                check_eq("read_wid", read_wid, cur_wid);
            end
            if (busy && cur_wr && age == 2) begin
                check_eq("write_addr", write_addr, cur_addr);
                check_eq("write_data", write_data, cur_new);
                check_eq("write_uuid", write_uuid, cur_uuid);
                check_eq("write_wid", write_wid, cur_wid);
                ref_mem[cur_addr] = cur_new;
            end
            if (exp_rv) begin
                check_eq("rsp_data", rsp_data, cur_old);
                check_eq("rsp_illegal", rsp_illegal, cur_ill);
                check_eq("rsp_uuid", rsp_uuid, cur_uuid);
                check_eq("rsp_wid", rsp_wid, cur_wid);
            end
            if (busy && age > 60) begin
                check_eq("rsp_timeout", 1'b1, 1'b0);
                busy = 1'b0;
            end
            if (reset) begin
                busy   = 1'b0;
                perf_m = '0;
            end else begin
                if (exp_rv && rsp_ready) begin
                    busy   = 1'b0;
                    perf_m = perf_m + 1;
                end
                if (req_valid && exp_ready) begin
                    cur_uuid = req_uuid;
                    cur_wid  = req_wid;
                    cur_addr = req_addr;
                    cur_old  = ref_mem[req_addr];
                    case (req_op)
                        2'b01:   cur_new = req_src;
                        2'b10:   cur_new = cur_old | req_src;
                        2'b11:   cur_new = cur_old & ~req_src;
                        default: cur_new = cur_old;
                    endcase
                    intent  = (req_op == 2'b01) || (req_op != 2'b00 && !req_src_zero);
                    ro      = (req_addr >= 12'hC00);
                    cur_ill = intent && ro;
                    cur_wr  = intent && !ro;
                    busy    = 1'b1;
                    age     = 0;
                end
            end
        end
    end

    int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom % 3) != 0;
            default: rsp_ready = 1'b0;
        endcase
    end

    // Presents one request (called at posedge+2) and returns at posedge+2 after it is accepted.
    task automatic send(input logic [11:0] a, input logic [1:0] op, input logic [XLEN-1:0] src,
                        input logic sz);
        logic acc;
        acc          = 1'b0;
        req_valid    = 1'b1;
        req_uuid     = {$urandom, $urandom};
        req_wid      = NWW'($urandom);
        req_addr     = a;
        req_op       = op;
        req_src      = src;
        req_src_zero = sz;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        req_addr  = 12'($urandom);
        req_src   = $urandom;
        if (!acc) check_eq("accept_timeout", 1'b0, 1'b1);
    endtask

    logic [11:0] pool [8];

    initial begin
        logic [11:0]     a;
        logic [1:0]      op;
        logic [XLEN-1:0] s;
        logic            sz;
        pool[0] = 12'h340; pool[1] = 12'hB00; pool[2] = 12'hF11; pool[3] = 12'hC00;
        pool[4] = 12'h300; pool[5] = 12'h7C0; pool[6] = 12'h001; pool[7] = 12'hFC2;
        for (int i = 0; i < 4096; i++) begin
            blk_mem[i] = $urandom;
            ref_mem[i] = blk_mem[i];
        end
        blk_mem[12'h340] = 32'h1234; ref_mem[12'h340] = 32'h1234;
        blk_mem[12'h300] = 32'hFF;   ref_mem[12'h300] = 32'hFF;
        blk_mem[12'hF11] = 32'h0;    ref_mem[12'hF11] = 32'h0;

        reset = 1'b1;
        @(posedge clk);
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #2;

        // Directed cases.
        send(12'h340, CSR_OP_RW, 32'hDEADBEEF, 1'b0);
        repeat (4) @(posedge clk); #2;
        send(12'hB00, CSR_OP_RS, 32'h0, 1'b1);
        repeat (4) @(posedge clk); #2;
        send(12'h300, CSR_OP_RC, 32'h0F, 1'b0);
        repeat (4) @(posedge clk); #2;
        send(12'hF11, CSR_OP_RW, 32'h5A5A, 1'b0);
        repeat (4) @(posedge clk); #2;

        // Response back-pressure, then a request accepted in the handshake cycle.
        rdy_mode = 2;
        send(12'h340, CSR_OP_RO, 32'h0, 1'b1);
        fork
            begin
                repeat (5) @(posedge clk);
                #1 rdy_mode = 0;
            end
        join_none
        send(12'h7C0, CSR_OP_RS, 32'h100, 1'b0);
        repeat (5) @(posedge clk); #2;

        // Reset while a write is pending in the READ cycle.
        send(12'h340, CSR_OP_RW, 32'h55, 1'b0);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (4) @(posedge clk); #2;

        // Randomized traffic with random back-pressure and gaps.
        rdy_mode = 1;
        for (int n = 0; n < 200; n++) begin
            a  = pool[$urandom_range(0, 7)];
            op = 2'($urandom);
            sz = ($urandom % 4) == 0;
            s  = sz ? '0 : $urandom;
            send(a, op, s, sz);
            if (($urandom % 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #2;
            end
        end
        rdy_mode = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("drain_busy", busy, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
